// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and the default operand width.
package seq_shift_add_multiplier_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_shift_add_multiplier_datapath.sv
// One radix-2 shift-add step: conditionally add the multiplicand into the
// upper half, keep the carry, then shift {carry, acc, mplier} right by one.
module mul_step_datapath #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] mcand,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] mplier,
   output logic [WIDTH-1:0] acc_nxt,
   output logic [WIDTH-1:0] mplier_nxt
);

   logic [WIDTH:0] sum;

   // Conditional add with carry-out, followed by the 1-bit right shift
   always_comb begin
      sum        = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
      acc_nxt    = sum[WIDTH:1];
      mplier_nxt = {sum[0], mplier[WIDTH-1:1]};
   end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential WIDTH x WIDTH -> 2*WIDTH shift-add multiplier with valid/ready
// handshakes on both sides. One partial product per clock.
// Optional two's-complement mode: define SEQ_MUL_SIGNED_EN.
module seq_shift_add_multiplier
   import seq_shift_add_multiplier_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_result,
   output logic               busy
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH-1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [2*WIDTH-1:0] out_result_q, out_result_d;
   logic [WIDTH-1:0]   acc_nxt, mplier_nxt;
   logic [WIDTH-1:0]   op_a, op_b;
   logic [2*WIDTH-1:0] prod;
`ifdef SEQ_MUL_SIGNED_EN
   logic               neg_q, neg_d;
`endif

   mul_step_datapath #(.WIDTH(WIDTH)) u_step (
      .mcand      (mcand_q),
      .acc        (acc_q),
      .mplier     (mplier_q),
      .acc_nxt    (acc_nxt),
      .mplier_nxt (mplier_nxt)
   );

   // Operand conditioning: magnitudes in signed mode (-2^(W-1) maps to 2^(W-1))
   always_comb begin
`ifdef SEQ_MUL_SIGNED_EN
      op_a = in_a[WIDTH-1] ? (~in_a + WIDTH'(1)) : in_a;
      op_b = in_b[WIDTH-1] ? (~in_b + WIDTH'(1)) : in_b;
      prod = neg_q ? (~{acc_nxt, mplier_nxt} + (2*WIDTH)'(1)) : {acc_nxt, mplier_nxt};
`else
      op_a = in_a;
      op_b = in_b;
      prod = {acc_nxt, mplier_nxt};
`endif
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         mcand_q      <= '0;
         mplier_q     <= '0;
         acc_q        <= '0;
         count_q      <= '0;
         out_result_q <= '0;
`ifdef SEQ_MUL_SIGNED_EN
         neg_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         mcand_q      <= mcand_d;
         mplier_q     <= mplier_d;
         acc_q        <= acc_d;
         count_q      <= count_d;
         out_result_q <= out_result_d;
`ifdef SEQ_MUL_SIGNED_EN
         neg_q        <= neg_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid)            state_d = ST_RUN;
         ST_RUN:  if (count_q == LAST_CNT) state_d = ST_DONE;
         ST_DONE: if (out_ready)           state_d = ST_IDLE;
         default:                          state_d = ST_IDLE;
      endcase
   end

   // Datapath updates: latch on accept, step in RUN, capture product on DONE entry
   always_comb begin
      mcand_d      = mcand_q;
      mplier_d     = mplier_q;
      acc_d        = acc_q;
      count_d      = count_q;
      out_result_d = out_result_q;
`ifdef SEQ_MUL_SIGNED_EN
      neg_d        = neg_q;
`endif
      case (state_q)
         ST_IDLE: if (in_valid) begin
            mcand_d  = op_a;
            mplier_d = op_b;
            acc_d    = '0;
            count_d  = '0;
`ifdef SEQ_MUL_SIGNED_EN
            neg_d    = in_a[WIDTH-1] ^ in_b[WIDTH-1];
`endif
         end
         ST_RUN: begin
            acc_d    = acc_nxt;
            mplier_d = mplier_nxt;
            count_d  = count_q + CNT_W'(1);
            if (count_q == LAST_CNT) out_result_d = prod;
         end
         default: ;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      in_ready   = (state_q == ST_IDLE);
      out_valid  = (state_q == ST_DONE);
      busy       = (state_q == ST_RUN) || (state_q == ST_DONE);
      out_result = out_result_q;
   end

endmodule
